// File: rtl/mac_dot_product_if.sv
// Sample-stream and result bus of the dot-product MAC engine.
// The master side feeds operands and abort requests; the slave side (the engine)
// returns the framed result, its overflow flag, a one-cycle strobe and busy status.
interface mac_dot_product_if #(
  parameter int A_W   = 24,
  parameter int B_W   = 18,
  parameter int ACC_W = 48
) ();
  logic                    valid_i;
  logic signed [A_W-1:0]   a_i;
  logic signed [B_W-1:0]   b_i;
  logic                    clear_i;
  logic signed [ACC_W-1:0] res_o;
  logic                    res_valid_o;
  logic                    ovf_o;
  logic                    busy_o;

  modport master (
    output valid_i, a_i, b_i, clear_i,
    input  res_o, res_valid_o, ovf_o, busy_o
  );

  modport slave (
    input  valid_i, a_i, b_i, clear_i,
    output res_o, res_valid_o, ovf_o, busy_o
  );
endinterface

// File: rtl/mac_dot_product.sv
// Pipelined signed multiply-accumulate engine producing one dot product per LEN
// valid samples. Stages: operand register, full-width product, accumulator.
// Overflow either saturates or wraps (SAT), and is reported per frame via a
// sticky flag. clear_i aborts the frame in progress without touching the last result.
module mac_dot_product #(
  parameter int A_W   = 24,
  parameter int B_W   = 18,
  parameter int ACC_W = 48,
  parameter int LEN   = 16,
  parameter int SAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mac_dot_product_if.slave bus
);

  localparam int PROD_W = A_W + B_W;
  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < A_W + B_W) begin : g_bad_acc_w
    $error("mac_dot_product: ACC_W must be at least A_W+B_W");
  end
  if (LEN < 1) begin : g_bad_len
    $error("mac_dot_product: LEN must be at least 1");
  end

  // The extended sum overflowed the accumulator when its two top bits disagree.
  function automatic logic sum_ovf(input logic signed [ACC_W:0] sum);
    return sum[ACC_W] ^ sum[ACC_W-1];
  endfunction

  // Clamp by the sign of the true sum in saturating mode, otherwise keep the low bits.
  function automatic logic signed [ACC_W-1:0] sat_wrap(input logic signed [ACC_W:0] sum);
    if (SAT != 0 && sum_ovf(sum)) begin
      return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return sum[ACC_W-1:0];
  endfunction

  logic signed [A_W-1:0]    a_p0;
  logic signed [B_W-1:0]    b_p0;
  logic                     vld_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic [CNT_W-1:0]         cnt_p2;
  logic                     ovf_acc_p2;

  logic signed [ACC_W-1:0]  res;
  logic                     res_valid;
  logic                     ovf;

  logic                     first_p2;
  logic                     last_p2;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     ovf_next;

  // Operand and product registers: pure data, qualified by the valid bits below.
  always_ff @(posedge clk_i) begin
    // S1: capture operands
    a_p0    <= bus.a_i;
    b_p0    <= bus.b_i;
    // S2: full-precision signed product
    prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
  end

  // Accumulator input: a new frame starts from zero and drops the previous sticky flag.
  always_comb begin
    first_p2 = (cnt_p2 == '0);
    last_p2  = (cnt_p2 == CNT_LAST);
    acc_base = first_p2 ? '0 : acc_p2;
    acc_sum  = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod_p1);
    acc_next = sat_wrap(acc_sum);
    ovf_next = (first_p2 ? 1'b0 : ovf_acc_p2) | sum_ovf(acc_sum);
  end

  // Valid pipeline, frame counter, accumulator and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      cnt_p2     <= '0;
      acc_p2     <= '0;
      ovf_acc_p2 <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (bus.clear_i) begin
        vld_p0     <= 1'b0;
        vld_p1     <= 1'b0;
        cnt_p2     <= '0;
        acc_p2     <= '0;
        ovf_acc_p2 <= 1'b0;
      end else begin
        // S1/S2: valid travels with the data
        vld_p0 <= bus.valid_i;
        vld_p1 <= vld_p0;
        // S3: accumulate, and publish the result on the last product of the frame
        if (vld_p1) begin
          acc_p2     <= acc_next;
          ovf_acc_p2 <= ovf_next;
          if (last_p2) begin
            cnt_p2    <= '0;
            res       <= acc_next;
            ovf       <= ovf_next;
            res_valid <= 1'b1;
          end else begin
            cnt_p2 <= cnt_p2 + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.res_o       = res;
  assign bus.res_valid_o = res_valid;
  assign bus.ovf_o       = ovf;
  assign bus.busy_o      = (cnt_p2 != '0) | vld_p0 | vld_p1;

endmodule

// File: tb/tb_mac_dot_product.sv
// Directed bench for mac_dot_product: three instances (LEN=4) cover the default
// 48-bit saturating build and 42-bit saturating / wrapping builds.
module tb_mac_dot_product;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic signed [63:0] qb_res[$];
  bit                 qb_ovf[$];
  logic signed [63:0] qs_res[$];
  bit                 qs_ovf[$];
  logic signed [63:0] qw_res[$];
  bit                 qw_ovf[$];

  always #5 clk = ~clk;

  mac_dot_product_if #(.A_W(24), .B_W(18), .ACC_W(48)) ifb ();
  mac_dot_product_if #(.A_W(24), .B_W(18), .ACC_W(42)) ifs ();
  mac_dot_product_if #(.A_W(24), .B_W(18), .ACC_W(42)) ifw ();

  mac_dot_product #(.A_W(24), .B_W(18), .ACC_W(48), .LEN(4), .SAT(1)) u_base (
    .clk_i(clk), .rst_i(rst), .bus(ifb));
  mac_dot_product #(.A_W(24), .B_W(18), .ACC_W(42), .LEN(4), .SAT(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .bus(ifs));
  mac_dot_product #(.A_W(24), .B_W(18), .ACC_W(42), .LEN(4), .SAT(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .bus(ifw));

  // Record every result strobe seen mid-cycle.
  always @(negedge clk) begin
    if (ifb.res_valid_o) begin qb_res.push_back(ifb.res_o); qb_ovf.push_back(ifb.ovf_o); end
    if (ifs.res_valid_o) begin qs_res.push_back(ifs.res_o); qs_ovf.push_back(ifs.ovf_o); end
    if (ifw.res_valid_o) begin qw_res.push_back(ifw.res_o); qw_ovf.push_back(ifw.ovf_o); end
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input bit v, input bit c, input int a, input int b);
    ifb.valid_i = v;
    ifb.clear_i = c;
    ifb.a_i     = 24'(a);
    ifb.b_i     = 18'(b);
  endtask

  task automatic drive_sw(input bit v, input int a, input int b);
    ifs.valid_i = v;  ifs.clear_i = 1'b0;  ifs.a_i = 24'(a);  ifs.b_i = 18'(b);
    ifw.valid_i = v;  ifw.clear_i = 1'b0;  ifw.a_i = 24'(a);  ifw.b_i = 18'(b);
  endtask

  task automatic feed_b(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin
      drive_b(1'b1, 1'b0, a, b);
      step();
    end
    drive_b(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive_b(1'b0, 1'b0, 0, 0);
    drive_sw(1'b0, 0, 0);
    step();
    step();
    chk("rst_res",  ifb.res_o, 0);
    chk("rst_rv",   ifb.res_valid_o, 0);
    chk("rst_ovf",  ifb.ovf_o, 0);
    chk("rst_busy", ifb.busy_o, 0);
    rst = 1'b0;
    step();

    // Basic frame: 1*2+2*2+3*2+4*2 = 20, strobe on the third edge after the last sample
    for (int i = 1; i <= 4; i++) begin
      drive_b(1'b1, 1'b0, i, 2);
      step();
    end
    drive_b(1'b0, 1'b0, 0, 0);
    chk("basic_e1_rv",   ifb.res_valid_o, 0);
    chk("basic_e1_busy", ifb.busy_o, 1);
    step();
    chk("basic_e2_rv", ifb.res_valid_o, 0);
    step();
    chk("basic_e3_rv",  ifb.res_valid_o, 1);
    chk("basic_res",    ifb.res_o, 20);
    chk("basic_ovf",    ifb.ovf_o, 0);
    chk("basic_idle_busy", ifb.busy_o, 0);
    step();
    chk("basic_strobe_1cyc", ifb.res_valid_o, 0);
    chk("basic_res_hold",    ifb.res_o, 20);
    qb_res.delete();  qb_ovf.delete();

    // Back-to-back frames, the second one with bubbles: -60 then -28
    feed_b(4, -5, 3);
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 1'b0, 7, -1);
      step();
      drive_b(1'b0, 1'b0, 0, 0);
      step();
    end
    for (int i = 0; i < 20 && qb_res.size() < 2; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("b2b_count", qb_res.size(), 2);
    if (qb_res.size() >= 2) begin
      chk("b2b_res0", qb_res[0], -60);
      chk("b2b_ovf0", qb_ovf[0], 0);
      chk("b2b_res1", qb_res[1], -28);
      chk("b2b_ovf1", qb_ovf[1], 0);
    end
    chk("b2b_busy_end", ifb.busy_o, 0);
    qb_res.delete();  qb_ovf.delete();

    // Clear mid-frame with a concurrent valid sample; next frame of ones gives 4
    feed_b(2, 5, 5);
    drive_b(1'b1, 1'b1, 9, 9);
    step();
    drive_b(1'b0, 1'b0, 0, 0);
    chk("clr_busy_fall", ifb.busy_o, 0);
    chk("clr_res_keep",  ifb.res_o, -28);
    feed_b(4, 1, 1);
    chk("clr_res_keep2", ifb.res_o, -28);
    for (int i = 0; i < 20 && qb_res.size() < 1; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("clr_count", qb_res.size(), 1);
    if (qb_res.size() >= 1) begin
      chk("clr_next_res", qb_res[0], 4);
      chk("clr_next_ovf", qb_ovf[0], 0);
    end
    qb_res.delete();  qb_ovf.delete();

    // Clear landing on the edge that would complete a frame discards it
    feed_b(4, 1, 2);
    step();
    drive_b(1'b0, 1'b1, 0, 0);
    step();
    drive_b(1'b0, 1'b0, 0, 0);
    chk("clr_last_rv",  ifb.res_valid_o, 0);
    chk("clr_last_res", ifb.res_o, 4);
    for (int i = 0; i < 6; i++) step();
    chk("clr_last_count", qb_res.size(), 0);
    chk("clr_last_busy",  ifb.busy_o, 0);

    // Reset after 3 of 4 samples; the next 4 samples of 2*2 give 16
    feed_b(3, 3, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_res",  ifb.res_o, 0);
    chk("mrst_rv",   ifb.res_valid_o, 0);
    chk("mrst_ovf",  ifb.ovf_o, 0);
    chk("mrst_busy", ifb.busy_o, 0);
    qb_res.delete();  qb_ovf.delete();
    feed_b(4, 2, 2);
    for (int i = 0; i < 20 && qb_res.size() < 1; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("mrst_count", qb_res.size(), 1);
    if (qb_res.size() >= 1) chk("mrst_next_res", qb_res[0], 16);

    // Saturation vs wrap at ACC_W=42: four products of 2^40, then four of 1
    qs_res.delete();  qs_ovf.delete();  qw_res.delete();  qw_ovf.delete();
    for (int i = 0; i < 4; i++) begin
      drive_sw(1'b1, -(1 << 23), -(1 << 17));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_sw(1'b1, 1, 1);
      step();
    end
    drive_sw(1'b0, 0, 0);
    for (int i = 0; i < 20 && (qs_res.size() < 2 || qw_res.size() < 2); i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("sat_count",  qs_res.size(), 2);
    chk("wrap_count", qw_res.size(), 2);
    if (qs_res.size() >= 2) begin
      chk("sat_res0", qs_res[0], (64'sd1 << 41) - 64'sd1);
      chk("sat_ovf0", qs_ovf[0], 1);
      chk("sat_res1", qs_res[1], 4);
      chk("sat_ovf1", qs_ovf[1], 0);
    end
    if (qw_res.size() >= 2) begin
      chk("wrap_res0", qw_res[0], 0);
      chk("wrap_ovf0", qw_ovf[0], 1);
      chk("wrap_res1", qw_res[1], 4);
      chk("wrap_ovf1", qw_ovf[1], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
